// File: rtl/vsm_pkg.sv
// Shared definitions for the vsm vector-scalar MAC array and its stream
// controller: the lane data width and the controller state encoding.
package vsm_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    SETTLE,
    DRAIN
  } vsm_ctrl_state_t;

endpackage

// File: rtl/vsm_drain_ser.sv
// Result serializer for vsm_stream_ctrl.
// Captures the SIZE lane results of the MAC array into a shadow register on
// a one-cycle capture pulse, then presents them lane 0..SIZE-1 on a
// valid/ready stream.
//   clk, reset      : clock, asynchronous active-low reset
//   capture         : load shadow from vsm_out and start draining
//   vsm_out         : packed lane results, lane i at [DATA_W*i +: DATA_W]
//   out_ready       : downstream ready
//   out_valid       : element valid (held until accepted)
//   out_data        : current element
//   out_last        : high with element SIZE-1
//   done            : pulses on the handshake of the last element
module vsm_drain_ser
  import vsm_pkg::*;
#(
  parameter int SIZE = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture,
  input  logic [DATA_W*SIZE-1:0] vsm_out,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   done
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

  logic [DATA_W-1:0] shadow [SIZE];
  logic [IDX_W-1:0]  idx;
  logic              valid_q;
  logic              out_hs;

  assign out_hs = valid_q & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      idx     <= '0;
      for (int i = 0; i < SIZE; i++) shadow[i] <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      idx     <= '0;
      for (int i = 0; i < SIZE; i++) shadow[i] <= vsm_out[DATA_W*i +: DATA_W];
    end else if (out_hs) begin
      if (idx == IDX_LAST) begin
        valid_q <= 1'b0;
        idx     <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Data and last are gated so the stream reads zero whenever it is idle.
  assign out_valid = valid_q;
  assign out_data  = valid_q ? shadow[idx] : '0;
  assign out_last  = valid_q & (idx == IDX_LAST);
  assign done      = out_hs & (idx == IDX_LAST);

endmodule

// File: rtl/vsm_stream_ctrl.sv
// Feed/drain controller for the vsm MAC array.
// Accepts DEPTH (vector, scalar) beats, presents each accepted beat to the
// array for exactly one clock, snapshots the SIZE lane results and streams
// them out one element per handshake, then clears the accumulators.
//   clk, reset           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake
//   in_a, in_b           : weight vector (lane i at in_a[8*i +: 8]), scalar
//   vsm_a, vsm_b         : beat driven into the array (zero when idle)
//   acc_reset            : active-low accumulator clear to the array
//   vsm_out              : lane results from the array
//   out_valid/out_ready  : output element handshake
//   out_data, out_last   : output element, last-lane flag
module vsm_stream_ctrl
  import vsm_pkg::*;
#(
  parameter int SIZE  = 6,
  parameter int DEPTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W*SIZE-1:0] in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic [DATA_W*SIZE-1:0] vsm_a,
  output logic [DATA_W-1:0]      vsm_b,
  output logic                   acc_reset,
  input  logic [DATA_W*SIZE-1:0] vsm_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(DEPTH - 1);

  vsm_ctrl_state_t state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             in_hs;
  logic             capture;
  logic             done;

  assign in_hs = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (in_hs) begin
        beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end

  // Outside an accepted beat the array is fed zeros so it accumulates nothing.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    acc_reset = 1'b1;
    vsm_a     = '0;
    vsm_b     = '0;
    capture   = 1'b0;
    case (state)
      CLEAR: begin
        acc_reset = 1'b0;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vsm_a = in_a;
          vsm_b = in_b;
          if (beat_cnt == BEAT_LAST) state_nxt = SETTLE;
        end
      end
      // The last beat lands in the array at the edge entering SETTLE, so its
      // output is complete during SETTLE and is captured at the end of it.
      SETTLE: begin
        capture   = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (done) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  vsm_drain_ser #(
    .SIZE(SIZE)
  ) u_drain (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .vsm_out  (vsm_out),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done)
  );

endmodule

// File: doc/vsm_stream_ctrl.md
# vsm_stream_ctrl

Streaming controller that sits in front of and behind the `vsm` vector-scalar MAC array. On the input side it accepts DEPTH (vector, scalar) beats over valid/ready and presents each accepted beat to the array for exactly one clock. After the last beat it snapshots the SIZE accumulated 8-bit results and drains them element-by-element on a valid/ready output stream. It then clears the accumulators and repeats. It is the feed/drain end of the `vsm` interface: it drives `vsm` `a`/`b`/`reset` and reads `vsm` `out`.

## Interface
- SIZE, 6, number of lanes (MACs) in the attached `vsm`; must equal its SIZE.
- DEPTH, 6, accumulation beats per result vector; DEPTH ≥ 1.
- clk  in  1  sole clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_a  in  8*SIZE  weight vector; lane i is in_a[8*i +: 8].
- in_b  in  8  scalar multiplier.
- vsm_a  out  8*SIZE  to `vsm.a`.
- vsm_b  out  8  to `vsm.b`.
- acc_reset  out  1  to `vsm.reset`; active-low, clears the MAC accumulators.
- vsm_out  in  8*SIZE  from `vsm.out`.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream ready.
- out_data  out  8  result element.
- out_last  out  1  high with element SIZE-1.

## Operation
- FSM states: CLEAR, ACCUM, SETTLE, DRAIN.
- **CLEAR**
  - acc_reset = 0; in_ready = 0; out_valid = 0.
  - Always lasts exactly 1 cycle, then goes to ACCUM.
- **ACCUM**
  - in_ready = 1.
  - On a handshake: vsm_a = in_a and vsm_b = in_b, combinationally for that cycle. The beat counter increments.
  - With no handshake: vsm_a = 0 and vsm_b = 0, so the MACs add 0.
  - The handshake that makes the count equal DEPTH moves the FSM to SETTLE and resets the count to 0.
- **SETTLE**
  - 1 cycle; in_ready = 0; vsm_a/vsm_b = 0.
  - At the end of this cycle vsm_out is captured into a SIZE×8 shadow register.
  - Next state: DRAIN with element index 0.
- **DRAIN**
  - out_valid = 1.
  - out_data = shadow[8*idx +: 8], lanes output in order 0..SIZE-1.
  - out_last = (idx == SIZE-1).
  - On each out handshake idx increments. The handshake on idx SIZE-1 moves the FSM to CLEAR.
  - out_data and out_last are held stable while out_valid & !out_ready.
- In every state other than ACCUM, vsm_a and vsm_b are 0 and in_ready is 0.
- Arithmetic: the controller does no arithmetic on data. Lane values are 8-bit modulo-256 MAC results, passed through unchanged.
- Counters:
  - beat counter is $clog2(DEPTH+1) bits.
  - element index is $clog2(SIZE) bits (minimum 1).
  - Neither counter ever exceeds its terminal value.
- Reset:
  - Asserting reset (0) at any time, including mid-ACCUM or mid-DRAIN, forces state CLEAR, zeroes both counters and zeroes the shadow register.
  - Any partial vector in progress is discarded.
- Reset values while reset = 0:
  - in_ready = 0, out_valid = 0, out_data = 0, out_last = 0.
  - acc_reset = 0 (accumulators held clear).
  - vsm_a = 0, vsm_b = 0.

## Timing
- Reset deassertion: the first rising edge after it leaves CLEAR. in_ready = 1 from the following cycle.
- Input throughput: 1 beat/cycle with in_valid held high. in_valid gaps only stall; they do not alter results.
- The MAC array accumulates at the same edge as the handshake. vsm_out reflects beat k one cycle after that edge.
- Latency, last input handshake (edge E) to first out_valid: 2 cycles.
  - E → SETTLE.
  - E+1 → capture, DRAIN.
- Output throughput: 1 element/cycle with out_ready held high. A full vector takes SIZE cycles.
- Minimum period per vector: DEPTH + 1 (SETTLE) + SIZE + 1 (CLEAR) cycles.
- in_ready and out_valid are never high in the same cycle.
- out_valid does not drop without a handshake.

## Structure
- Package `vsm_pkg`:
  - DATA_W = 8.
  - State enum `vsm_ctrl_state_t` {CLEAR, ACCUM, SETTLE, DRAIN}.
  - These are shared with the `vsm` / `mac` blocks.
- One natural sub-module: `vsm_drain_ser`. It holds the shadow register, element index, out_valid/out_data/out_last, and a `done` pulse back to the FSM.
- The FSM, beat counter and input muxing stay in `vsm_stream_ctrl`.
- `vsm` is not instantiated inside. The bench and the parent instantiate both and wire them.

## Test plan
- **Basic accumulation.** SIZE=6, DEPTH=6. Six beats of in_a lanes all 1 with in_b = 2, back-to-back. Required: 6 elements of 12, out_last on the 6th, first out_valid 2 cycles after the last handshake.
- **Modulo wrap.** Lane 0 = 16, other lanes = lane index, in_b = 4, 6 beats. Required: lane 0 = 384 mod 256 = 128; lane i = 24·i.
- **Input gaps.** Same data as the basic test, with in_valid low for 3 cycles between each beat. Required: identical outputs; vsm_a/vsm_b = 0 on all gap cycles.
- **Output backpressure.** out_ready pattern 1,0,0,1,0,1,1,1,…. Required: every element delivered once, in order, stable while stalled; in_ready stays 0 until DRAIN and CLEAR complete.
- **Back-to-back vectors.** Two vectors (basic, then wrap data). Required: second result equals wrap-test values, proving the CLEAR pulse: acc_reset = 0 for exactly 1 cycle between them.
- **Reset mid-operation.** Assert reset after 3 of 6 beats, and separately after 2 of 6 output elements. Required: all outputs return to their reset values immediately; a subsequent full vector produces correct values with no residue.
